// File: rtl/alu_pkg.sv
// Shared encodings and the condition evaluator for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SBC  = 4'b0111;
  localparam logic [3:0] OP_RSB  = 4'b1000;
  localparam logic [3:0] OP_MOV  = 4'b1001;
  localparam logic [3:0] OP_TST  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_CMN  = 4'b1100;
  localparam logic [3:0] OP_MOVI = 4'b1101;
  localparam logic [3:0] OP_BIC  = 4'b1110;

  localparam logic [3:0] CC_AL = 4'b0000;
  localparam logic [3:0] CC_EQ = 4'b0001;
  localparam logic [3:0] CC_NE = 4'b0010;
  localparam logic [3:0] CC_CS = 4'b0011;
  localparam logic [3:0] CC_CC = 4'b0100;
  localparam logic [3:0] CC_MI = 4'b0101;
  localparam logic [3:0] CC_PL = 4'b0110;
  localparam logic [3:0] CC_VS = 4'b0111;
  localparam logic [3:0] CC_VC = 4'b1000;
  localparam logic [3:0] CC_HI = 4'b1001;
  localparam logic [3:0] CC_LS = 4'b1010;
  localparam logic [3:0] CC_GE = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GT = 4'b1101;
  localparam logic [3:0] CC_LE = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam logic [2:0] SR_NONE = 3'b000;
  localparam logic [2:0] SR_LSL  = 3'b001;
  localparam logic [2:0] SR_LSR  = 3'b010;
  localparam logic [2:0] SR_ASR  = 3'b011;
  localparam logic [2:0] SR_ROR  = 3'b100;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ARM condition evaluation against an {N,Z,C,V} flag vector.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      CC_AL:   cond_pass = 1'b1;
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = c;
      CC_CC:   cond_pass = !c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = c && !z;
      CC_LS:   cond_pass = !c || z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z && (n == v);
      CC_LE:   cond_pass = z || (n != v);
      CC_NV:   cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Barrel pre-shifter for operand B; keep_c means the carry comes from the flag register.
module alu_shifter
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       sr_cont,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             keep_c
);

  logic [WIDTH:0]   wide_l;
  logic [WIDTH:0]   wide_r;
  logic [WIDTH:0]   wide_a;
  logic [WIDTH-1:0] rot;

  // One extra bit on the shifted-out side captures the last bit lost.
  assign wide_l = {1'b0, value} << amount;
  assign wide_r = {value, 1'b0} >> amount;
  assign wide_a = $signed({value, 1'b0}) >>> amount;
  assign rot    = (value >> amount) | (value << (WIDTH - 32'(amount)));

  always_comb begin
    result = value;
    carry  = 1'b0;
    keep_c = 1'b1;
    if (amount != '0) begin
      case (sr_cont)
        SR_NONE: ;
        SR_LSL: begin
          result = wide_l[WIDTH-1:0];
          carry  = wide_l[WIDTH];
          keep_c = 1'b0;
        end
        SR_LSR: begin
          result = wide_r[WIDTH:1];
          carry  = wide_r[0];
          keep_c = 1'b0;
        end
        SR_ASR: begin
          result = wide_a[WIDTH:1];
          carry  = wide_a[0];
          keep_c = 1'b0;
        end
        SR_ROR: begin
          result = rot;
          carry  = rot[WIDTH-1];
          keep_c = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with pre-shift, conditional execution and NZCV flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [15:0]      Immediate,
  input  logic [3:0]       Opcode,
  input  logic [3:0]       Cond,
  input  logic [2:0]       SR_Cont,
  input  logic [SHW-1:0]   SR_Bit,
  input  logic             S,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Exec,
  output logic             Out_Wr,
  output logic [3:0]       Flags
);

  localparam int unsigned W1 = WIDTH + 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_sc, s1_keep_c, s1_s;
  logic [15:0]      s1_imm;
  logic [3:0]       s1_op, s1_cond;

  logic [WIDTH-1:0] sh_result;
  logic             sh_carry, sh_keep;

  logic             advance;
  logic             pass, arith, cmp_op, reserved, ci, shift_c;
  logic [WIDTH-1:0] x, y, logic_res, result;
  logic [WIDTH:0]   sum;
  logic [3:0]       next_flags;

  assign advance  = !Out_Valid || Out_Ready;
  assign In_Ready = !s1_valid || advance;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value   (In2),
    .sr_cont (SR_Cont),
    .amount  (SR_Bit),
    .result  (sh_result),
    .carry   (sh_carry),
    .keep_c  (sh_keep)
  );

  // Execute stage; a flag-sourced shifter carry is read here so it sees every older commit.
  always_comb begin
    x         = s1_a;
    y         = s1_b;
    ci        = 1'b0;
    arith     = 1'b0;
    cmp_op    = 1'b0;
    reserved  = 1'b0;
    logic_res = '0;
    case (s1_op)
      OP_AND:  logic_res = s1_a & s1_b;
      OP_OR:   logic_res = s1_a | s1_b;
      OP_XOR:  logic_res = s1_a ^ s1_b;
      OP_NOT:  logic_res = ~s1_b;
      OP_ADD:  arith = 1'b1;
      OP_ADC:  begin arith = 1'b1; ci = Flags[FLAG_C]; end
      OP_SUB:  begin arith = 1'b1; y = ~s1_b; ci = 1'b1; end
      OP_SBC:  begin arith = 1'b1; y = ~s1_b; ci = Flags[FLAG_C]; end
      OP_RSB:  begin arith = 1'b1; x = s1_b; y = ~s1_a; ci = 1'b1; end
      OP_MOV:  logic_res = s1_b;
      OP_TST:  begin logic_res = s1_a & s1_b; cmp_op = 1'b1; end
      OP_CMP:  begin arith = 1'b1; y = ~s1_b; ci = 1'b1; cmp_op = 1'b1; end
      OP_CMN:  begin arith = 1'b1; cmp_op = 1'b1; end
      OP_MOVI: logic_res = WIDTH'(s1_imm);
      OP_BIC:  logic_res = s1_a & ~s1_b;
      default: reserved = 1'b1;
    endcase
    sum     = W1'(x) + W1'(y) + W1'(ci);
    shift_c = s1_keep_c ? Flags[FLAG_C] : s1_sc;
    result  = reserved ? '0 : (arith ? sum[WIDTH-1:0] : logic_res);

    next_flags         = Flags;
    next_flags[FLAG_N] = result[WIDTH-1];
    next_flags[FLAG_Z] = (result == '0);
    next_flags[FLAG_C] = arith ? sum[WIDTH] : shift_c;
    next_flags[FLAG_V] = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]))
                               : Flags[FLAG_V];
    pass = cond_pass(s1_cond, Flags);
  end

  // Stage-1 payload; only qualified by s1_valid so it needs no reset.
  always_ff @(posedge Clk) begin
    if (In_Valid && In_Ready) begin
      s1_a      <= In1;
      s1_b      <= sh_result;
      s1_sc     <= sh_carry;
      s1_keep_c <= sh_keep;
      s1_imm    <= Immediate;
      s1_op     <= Opcode;
      s1_cond   <= Cond;
      s1_s      <= S;
    end
  end

  // Valids, output register and architectural flags.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid  <= 1'b0;
      Out_Valid <= 1'b0;
      Out       <= '0;
      Out_Exec  <= 1'b0;
      Out_Wr    <= 1'b0;
      Flags     <= 4'b0000;
    end else begin
      if (In_Ready) s1_valid <= In_Valid;
      if (advance) begin
        Out_Valid <= s1_valid;
        if (s1_valid) begin
          if (pass) begin
            Out      <= result;
            Out_Exec <= 1'b1;
            Out_Wr   <= !reserved && !cmp_op;
            if (!reserved && (s1_s || cmp_op)) Flags <= next_flags;
          end else begin
            Out      <= '0;
            Out_Exec <= 1'b0;
            Out_Wr   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic vs a sequential ISA model.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SUB = 4'd6,  OP_SBC  = 4'd7;
  localparam logic [3:0] OP_RSB = 4'd8,  OP_MOV = 4'd9,  OP_TST = 4'd10, OP_CMP  = 4'd11;
  localparam logic [3:0] OP_CMN = 4'd12, OP_MOVI = 4'd13, OP_BIC = 4'd14, OP_RSVD = 4'd15;
  localparam logic [3:0] C_AL = 4'd0, C_EQ = 4'd1, C_NE = 4'd2;
  localparam logic [2:0] SH_NONE = 3'd0, SH_ASR = 3'd3, SH_ROR = 3'd4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             Clk = 1'b0;
  logic             Rst_n, In_Valid, In_Ready, S, Out_Valid, Out_Ready, Out_Exec, Out_Wr;
  logic [WIDTH-1:0] In1, In2, Out;
  logic [15:0]      Immediate;
  logic [3:0]       Opcode, Cond, Flags;
  logic [2:0]       SR_Cont;
  logic [4:0]       SR_Bit;

  always #5 Clk = ~Clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In1(In1), .In2(In2), .Immediate(Immediate), .Opcode(Opcode), .Cond(Cond),
    .SR_Cont(SR_Cont), .SR_Bit(SR_Bit), .S(S), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out(Out), .Out_Exec(Out_Exec), .Out_Wr(Out_Wr), .Flags(Flags)
  );

  typedef struct packed {
    logic [31:0] out;
    logic        exec;
    logic        wr;
    logic [3:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e, mon_pop;
  logic [3:0]  mflags;
  int          n_checks = 0;
  int          n_fail = 0;
  int          retired = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Architectural reference: one instruction executed against the current flags.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [3:0] cond,
                                  input logic [31:0] a, input logic [31:0] braw,
                                  input logic [15:0] imm, input logic [2:0] sr,
                                  input logic [4:0] amt, input logic s, input logic [3:0] fl);
    exp_t e;
    logic n, z, c, v, pass, sc, nc, nv, arith, cmpop, rsvd;
    logic [31:0] b, r;
    longint ua, ub, sa, sbv, u, sres;
    int sh;
    {n, z, c, v} = fl;
    sh = int'(amt);
    b  = braw;
    sc = c;
    if (sh != 0) begin
      case (sr)
        3'd1: begin b = braw << sh; sc = braw[32 - sh]; end
        3'd2: begin b = braw >> sh; sc = braw[sh - 1]; end
        3'd3: begin b = 32'($signed(braw) >>> sh); sc = braw[sh - 1]; end
        3'd4: begin b = (braw >> sh) | (braw << (32 - sh)); sc = b[31]; end
        default: ;
      endcase
    end
    case (cond)
      4'd0:  pass = 1'b1;
      4'd1:  pass = z;
      4'd2:  pass = !z;
      4'd3:  pass = c;
      4'd4:  pass = !c;
      4'd5:  pass = n;
      4'd6:  pass = !n;
      4'd7:  pass = v;
      4'd8:  pass = !v;
      4'd9:  pass = c && !z;
      4'd10: pass = !c || z;
      4'd11: pass = (n == v);
      4'd12: pass = (n != v);
      4'd13: pass = !z && (n == v);
      4'd14: pass = z || (n != v);
      default: pass = 1'b0;
    endcase
    ua = 64'(a); ub = 64'(b); sa = 64'($signed(a)); sbv = 64'($signed(b));
    arith = 1'b0; cmpop = 1'b0; rsvd = 1'b0; r = '0; nc = sc; nv = v; u = 0; sres = 0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~b;
      OP_ADD:  begin arith = 1'b1; u = ua + ub; sres = sa + sbv; nc = u[32]; end
      OP_ADC:  begin arith = 1'b1; u = ua + ub + 64'(c); sres = sa + sbv + 64'(c); nc = u[32]; end
      OP_SUB:  begin arith = 1'b1; u = ua - ub; sres = sa - sbv; nc = (u >= 0); end
      OP_SBC:  begin arith = 1'b1; u = ua - ub - 64'(!c); sres = sa - sbv - 64'(!c); nc = (u >= 0); end
      OP_RSB:  begin arith = 1'b1; u = ub - ua; sres = sbv - sa; nc = (u >= 0); end
      OP_MOV:  r = b;
      OP_TST:  begin r = a & b; cmpop = 1'b1; end
      OP_CMP:  begin arith = 1'b1; cmpop = 1'b1; u = ua - ub; sres = sa - sbv; nc = (u >= 0); end
      OP_CMN:  begin arith = 1'b1; cmpop = 1'b1; u = ua + ub; sres = sa + sbv; nc = u[32]; end
      OP_MOVI: r = 32'(imm);
      OP_BIC:  r = a & ~b;
      default: rsvd = 1'b1;
    endcase
    if (arith) begin
      r  = u[31:0];
      nv = (sres > SMAX) || (sres < SMIN);
    end
    e.flags = fl;
    e.exec  = pass;
    e.wr    = pass && !rsvd && !cmpop;
    e.out   = (pass && !rsvd) ? r : 32'd0;
    if (pass && !rsvd && (s || cmpop)) e.flags = {r[31], (r == 32'd0), nc, nv};
    return e;
  endfunction

  // Scoreboard: model each accepted op in issue order, compare whatever sits in stage 2.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
      mflags = 4'b0000;
    end else begin
      if (Out_Valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(Out_Valid), 64'd0);
        end else begin
          check("out",   64'(Out),      64'(exp_q[0].out));
          check("exec",  64'(Out_Exec), 64'(exp_q[0].exec));
          check("wr",    64'(Out_Wr),   64'(exp_q[0].wr));
          check("flags", 64'(Flags),    64'(exp_q[0].flags));
          if (Out_Ready) begin
            mon_pop = exp_q.pop_front();
            retired++;
          end
        end
      end
      if (In_Valid && In_Ready) begin
        mon_e  = ref_op(Opcode, Cond, In1, In2, Immediate, SR_Cont, SR_Bit, S, mflags);
        mflags = mon_e.flags;
        exp_q.push_back(mon_e);
      end
    end
  end

  task automatic load_op(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input logic [2:0] sr,
                         input logic [4:0] amt, input logic s);
    Opcode = op; Cond = cond; In1 = a; In2 = b; Immediate = imm;
    SR_Cont = sr; SR_Bit = amt; S = s;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [2:0] sr,
                       input logic [4:0] amt, input logic s);
    int n = 0;
    load_op(op, cond, a, b, imm, sr, amt, s);
    In_Valid = 1'b1;
    @(negedge Clk);
    while (!In_Ready && n < 50) begin n++; @(negedge Clk); end
    check("issue_ready", 64'(In_Ready), 64'd1);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] eo, input logic ee,
                            input logic ew, input logic [3:0] ef);
    int n = 0;
    @(negedge Clk);
    while (!Out_Valid && n < 20) begin n++; @(negedge Clk); end
    check({tag, "_valid"}, 64'(Out_Valid), 64'd1);
    check({tag, "_out"},   64'(Out),       64'(eo));
    check({tag, "_exec"},  64'(Out_Exec),  64'(ee));
    check({tag, "_wr"},    64'(Out_Wr),    64'(ew));
    check({tag, "_flags"}, 64'(Flags),     64'(ef));
    @(posedge Clk); #1;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int         k, ret0, seen, drain_n;
  bit         acc, have0;
  logic [31:0] bp_out0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    load_op(OP_AND, C_AL, '0, '0, '0, SH_NONE, '0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", 64'(Out_Valid), 64'd0);
    check("rst_out",       64'(Out),       64'd0);
    check("rst_exec",      64'(Out_Exec),  64'd0);
    check("rst_wr",        64'(Out_Wr),    64'd0);
    check("rst_flags",     64'(Flags),     64'd0);
    check("rst_in_ready",  64'(In_Ready),  64'd1);
    Rst_n = 1'b1;

    issue(OP_CMP, C_AL, 32'd15, 32'd20, '0, SH_NONE, '0, 1'b1);
    expect_out("cmp_15_20", 32'hFFFF_FFFB, 1'b1, 1'b0, 4'b1000);
    issue(OP_CMP, C_AL, 32'd5, 32'd5, '0, SH_NONE, '0, 1'b1);
    expect_out("cmp_5_5", 32'h0, 1'b1, 1'b0, 4'b0110);
    issue(OP_CMP, C_AL, 32'd30, 32'd25, '0, SH_NONE, '0, 1'b1);
    expect_out("cmp_30_25", 32'd5, 1'b1, 1'b0, 4'b0010);
    issue(OP_CMP, C_AL, 32'd0, 32'h8000_0000, '0, SH_NONE, '0, 1'b1);
    expect_out("cmp_0_min", 32'h8000_0000, 1'b1, 1'b0, 4'b1001);

    issue(OP_CMP, C_AL, 32'd5, 32'd5, '0, SH_NONE, '0, 1'b1);
    expect_out("cmp_again", 32'h0, 1'b1, 1'b0, 4'b0110);
    issue(OP_ADD, C_EQ, 32'd1, 32'd2, '0, SH_NONE, '0, 1'b0);
    expect_out("add_eq", 32'd3, 1'b1, 1'b1, 4'b0110);
    issue(OP_ADD, C_NE, 32'd1, 32'd2, '0, SH_NONE, '0, 1'b0);
    expect_out("add_ne", 32'd0, 1'b0, 1'b0, 4'b0110);

    issue(OP_ADD, C_AL, 32'hFFFF_FFFF, 32'd1, '0, SH_NONE, '0, 1'b1);
    issue(OP_ADC, C_AL, 32'd0, 32'd0, '0, SH_NONE, '0, 1'b0);
    expect_out("add_wrap", 32'd0, 1'b1, 1'b1, 4'b0110);
    expect_out("adc_chain", 32'd1, 1'b1, 1'b1, 4'b0110);

    issue(OP_MOV, C_AL, 32'd0, 32'h8000_0000, '0, SH_ASR, 5'd4, 1'b1);
    expect_out("mov_asr4", 32'hF800_0000, 1'b1, 1'b1, 4'b1000);
    issue(OP_MOV, C_AL, 32'd0, 32'h0000_0001, '0, SH_ROR, 5'd1, 1'b1);
    expect_out("mov_ror1", 32'h8000_0000, 1'b1, 1'b1, 4'b1010);
    issue(OP_MOVI, C_AL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hBEEF, SH_NONE, '0, 1'b0);
    expect_out("movi", 32'h0000_BEEF, 1'b1, 1'b1, 4'b1010);
    issue(OP_RSVD, C_AL, 32'd7, 32'd9, '0, SH_NONE, '0, 1'b1);
    expect_out("reserved", 32'd0, 1'b1, 1'b0, 4'b1010);

    // Backpressure: four ADDs offered while the consumer stalls, then released.
    Out_Ready = 1'b0; k = 0; have0 = 1'b0; bp_out0 = '0;
    load_op(OP_ADD, C_AL, 32'd1, 32'd100, '0, SH_NONE, '0, 1'b0);
    In_Valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge Clk);
      acc = In_Valid && In_Ready;
      if (Out_Valid) begin
        if (!have0) begin bp_out0 = Out; have0 = 1'b1; end
        else check("bp_stable", 64'(Out), 64'(bp_out0));
      end
      @(posedge Clk); #1;
      if (acc) begin
        k++;
        if (k < 4) load_op(OP_ADD, C_AL, 32'(k + 1), 32'd100, '0, SH_NONE, '0, 1'b0);
        else In_Valid = 1'b0;
      end
    end
    check("bp_accepted", 64'(k), 64'd2);
    check("bp_in_ready", 64'(In_Ready), 64'd0);
    check("bp_first_out", 64'(bp_out0), 64'd101);
    ret0 = retired;
    Out_Ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge Clk);
      acc = In_Valid && In_Ready;
      @(posedge Clk); #1;
      if (acc) begin
        k++;
        if (k < 4) load_op(OP_ADD, C_AL, 32'(k + 1), 32'd100, '0, SH_NONE, '0, 1'b0);
        else In_Valid = 1'b0;
      end
    end
    check("bp_all_issued", 64'(k), 64'd4);
    check("bp_retire_rate", 64'(retired - ret0), 64'd4);
    In_Valid = 1'b0;

    // Reset with both stages occupied.
    Out_Ready = 1'b0;
    issue(OP_CMP, C_AL, 32'd15, 32'd20, '0, SH_NONE, '0, 1'b1);
    issue(OP_ADD, C_AL, 32'd1, 32'd2, '0, SH_NONE, '0, 1'b0);
    check("mid_flags_pre", 64'(Flags), 64'b1000);
    check("mid_valid_pre", 64'(Out_Valid), 64'd1);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    check("mid_rst_valid", 64'(Out_Valid), 64'd0);
    check("mid_rst_flags", 64'(Flags), 64'd0);
    check("mid_rst_ready", 64'(In_Ready), 64'd1);
    Rst_n = 1'b1;
    Out_Ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Out_Valid) seen++;
    end
    check("mid_rst_no_stale", 64'(seen), 64'd0);
    @(posedge Clk); #1;

    // Randomized traffic with random stalls on both sides.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge Clk);
      acc = In_Valid && In_Ready;
      @(posedge Clk); #1;
      if (acc || !In_Valid) begin
        load_op(4'($urandom), (($urandom % 3) == 0) ? 4'($urandom) : C_AL,
                rnd_word(), rnd_word(), 16'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
        In_Valid = ($urandom % 4) != 0;
      end
      Out_Ready = ($urandom % 4) != 0;
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    drain_n = 0;
    while (exp_q.size() != 0 && drain_n < 20) begin
      @(posedge Clk); #1;
      drain_n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("final_flags", 64'(Flags), 64'(mflags));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
